// File: rtl/mm_arbiter_if.sv
// Client request/response bundle plus the downstream main-memory port of mm_arbiter.
// The master modport is the arbiter's view; slave is the clients-plus-memory side.
interface mm_arbiter_if #(
  parameter int NUM_OF_REQS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128
);
  logic [NUM_OF_REQS-1:0]        req_valid;
  logic [NUM_OF_REQS-1:0]        req_we;
  logic [NUM_OF_REQS*ADDR_W-1:0] req_addr;
  logic [NUM_OF_REQS*DATA_W-1:0] req_wdata;
  logic                          ready;
  logic [NUM_OF_REQS-1:0]        res_valid;
  logic [DATA_W-1:0]             res_rdata;
  logic                          res_err;

  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_req_we;
  logic [ADDR_W-1:0]             mem_req_addr;
  logic [DATA_W-1:0]             mem_req_wdata;
  logic                          mem_res_valid;
  logic [DATA_W-1:0]             mem_res_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output ready, res_valid, res_rdata, res_err,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_res_valid, mem_res_rdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  ready, res_valid, res_rdata, res_err,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_res_valid, mem_res_rdata
  );
endinterface

// File: rtl/mm_arbiter.sv
// Round-robin arbiter funnelling NUM_OF_REQS clients onto one main-memory port, one transaction in flight.
// Define MM_ARB_TIMEOUT_EN to add a WAIT-state watchdog that answers with res_err after TIMEOUT_CYCLES.
module mm_arbiter #(
  parameter int NUM_OF_REQS    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         rst_n,
  mm_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_OF_REQS > 1) ? $clog2(NUM_OF_REQS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [IDX_W-1:0]       last_grant_reg;
  logic [NUM_OF_REQS-1:0] res_valid_reg;
  logic [DATA_W-1:0]      res_rdata_reg;
  logic                   mem_req_valid_reg;
  logic                   mem_req_we_reg;
  logic [ADDR_W-1:0]      mem_req_addr_reg;
  logic [DATA_W-1:0]      mem_req_wdata_reg;

  logic [ADDR_W-1:0]      client_addr  [NUM_OF_REQS];
  logic [DATA_W-1:0]      client_wdata [NUM_OF_REQS];
  logic [NUM_OF_REQS-1:0] idx_onehot;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;
  logic                   grant_found;

  for (genvar gi = 0; gi < NUM_OF_REQS; gi++) begin : g_client
    assign client_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign client_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    assign idx_onehot[gi]   = (idx_reg == IDX_W'(gi));
  end

  // Search starts one past the last served client and wraps, so every client waits at most N-1 grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    cand        = last_grant_reg;
    for (int i = 1; i <= NUM_OF_REQS; i++) begin
      cand = IDX_W'((32'(last_grant_reg) + 32'(i)) % 32'(NUM_OF_REQS));
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef MM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt_reg;
  logic             res_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      last_grant_reg    <= IDX_W'(NUM_OF_REQS - 1);
      res_valid_reg     <= '0;
      res_rdata_reg     <= '0;
      mem_req_valid_reg <= 1'b0;
      mem_req_we_reg    <= 1'b0;
      mem_req_addr_reg  <= '0;
      mem_req_wdata_reg <= '0;
`ifdef MM_ARB_TIMEOUT_EN
      tcnt_reg          <= '0;
      res_err_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            idx_reg           <= grant_idx;
            mem_req_we_reg    <= bus.req_we[grant_idx];
            mem_req_addr_reg  <= client_addr[grant_idx];
            mem_req_wdata_reg <= client_wdata[grant_idx];
            mem_req_valid_reg <= 1'b1;
            state_reg         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
            state_reg         <= WAIT;
`ifdef MM_ARB_TIMEOUT_EN
            tcnt_reg          <= '0;
`endif
          end
        end
        WAIT: begin
          // A real response wins over an expiry landing in the same cycle.
          if (bus.mem_res_valid) begin
            res_rdata_reg <= bus.mem_res_rdata;
            res_valid_reg <= idx_onehot;
            state_reg     <= RESP;
`ifdef MM_ARB_TIMEOUT_EN
            res_err_reg   <= 1'b0;
          end else if (tcnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            res_rdata_reg <= '0;
            res_err_reg   <= 1'b1;
            res_valid_reg <= idx_onehot;
            state_reg     <= RESP;
          end else begin
            tcnt_reg      <= tcnt_reg + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          res_valid_reg  <= '0;
          last_grant_reg <= idx_reg;
          state_reg      <= IDLE;
`ifdef MM_ARB_TIMEOUT_EN
          res_err_reg    <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready         = (state_reg == IDLE);
  assign bus.res_valid     = res_valid_reg;
  assign bus.res_rdata     = res_rdata_reg;
  assign bus.mem_req_valid = mem_req_valid_reg;
  assign bus.mem_req_we    = mem_req_we_reg;
  assign bus.mem_req_addr  = mem_req_addr_reg;
  assign bus.mem_req_wdata = mem_req_wdata_reg;
`ifdef MM_ARB_TIMEOUT_EN
  assign bus.res_err       = res_err_reg;
`else
  assign bus.res_err       = 1'b0;
`endif
endmodule

// File: doc/mm_arbiter.md
# mm_arbiter

Round-robin arbiter between `NUM_OF_REQS` main-memory clients and one main-memory port, placed directly upstream of main memory. It acts as the host side of the client request/response bundle. It grants one client at a time and forwards that 128-bit request downstream. It returns the single response to the granted client's index, with one transaction outstanding at a time.

## Interface
- `NUM_OF_REQS`, 4: number of client ports (≥2).
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 128: transfer unit width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only with the timeout macro.

Ports:
- `clk` in 1: single clock. One clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_OF_REQS: per-client request pending.
- `req_we` in NUM_OF_REQS: per-client write (1) / read (0).
- `req_addr` in NUM_OF_REQS×ADDR_W: per-client address.
- `req_wdata` in NUM_OF_REQS×DATA_W: per-client write data.
- `ready` out 1: arbiter can accept a request this cycle.
- `res_valid` out NUM_OF_REQS: one-hot, one-cycle response pulse; index equals request index.
- `res_rdata` out DATA_W: response data, shared by all clients.
- `res_err` out 1: response is a timeout error; qualified by `res_valid`.
- `mem_req_valid` out 1: downstream request.
- `mem_req_ready` in 1: downstream accepts.
- `mem_req_we` out 1: downstream write/read.
- `mem_req_addr` out ADDR_W: downstream address.
- `mem_req_wdata` out DATA_W: downstream write data.
- `mem_res_valid` in 1: downstream response, one cycle.
- `mem_res_rdata` in DATA_W: downstream response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `ready`=1.
  - `req_valid` is sampled only in IDLE.
  - If any bit is set, the winner is the first set bit searching from `(last_grant+1) mod NUM_OF_REQS` upward with wrap-around.
  - Latch the winner index, `we`, `addr` and `wdata`, then go to ISSUE.
- **ISSUE**
  - `mem_req_valid`=1, driven from the latched fields, which stay stable until accepted.
  - On `mem_req_ready`=1, go to WAIT.
- **WAIT**
  - On `mem_res_valid`=1, latch `mem_res_rdata` and go to RESP.
  - A write also completes on `mem_res_valid`; its rdata is forwarded unchanged and carries no meaning.
- **RESP**
  - `res_valid[idx]`=1 for exactly one cycle.
  - `res_rdata` is the latched data.
  - `last_grant` is set to idx.
  - Go to IDLE.
- Client rules:
  - Hold `req_valid` and its fields stable from assertion until its `res_valid` pulse.
  - Deassert `req_valid` in the cycle after the pulse; a still-high `req_valid` in IDLE is a new request.
- `mem_res_valid` in IDLE, ISSUE or RESP is ignored (no state change).
- `res_rdata` holds its last value between pulses.

## Timing
- Reset values:
  - state=IDLE
  - `ready`=1
  - `res_valid`=0
  - `res_rdata`=0
  - `res_err`=0
  - `mem_req_valid`=0
  - `mem_req_we`=0, `mem_req_addr`=0, `mem_req_wdata`=0
  - `last_grant`=NUM_OF_REQS−1, so client 0 has first priority
  - timeout counter=0
- Reset asserted mid-transaction (any state) returns to these values on the next edge. The outstanding downstream transaction is abandoned; its late response arrives in IDLE and is ignored.
- Request sampled in IDLE at cycle 0:
  - `mem_req_valid` from cycle 1.
  - With `mem_req_ready` at cycle 1, WAIT from cycle 2.
  - `mem_res_valid` at cycle k≥2 gives `res_valid` at k+1.
  - Minimum request-to-response latency is 3 cycles.
- Back-to-back: the next grant can be sampled in the cycle after RESP, so one transaction per 4 cycles minimum.
- `ready` is registered-state decoded: 1 only in IDLE.

## Configuration
- Macro: `MM_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - Reaching `TIMEOUT_CYCLES` without `mem_res_valid` forces RESP with `res_err`=1 and `res_rdata`=0.
  - `mem_res_valid` in the same cycle as expiry takes precedence: normal response, `res_err`=0.
  - ISSUE is not timed.
- Undefined: no counter; `res_err` tied to 0; WAIT waits indefinitely.

## Test plan
- Single read: client 2 requests addr 0x100 with memory returning 0xDEAD…BEEF two cycles after accept -> `mem_req_addr`=0x100 at cycle 1; `res_valid`=4'b0100 with that data at cycle 4; `ready`=0 during cycles 1–4.
- Contention: all four `req_valid` asserted together from reset and held until served -> grants in order 0,1,2,3; each `res_valid` is one-hot and one cycle wide.
- Fairness: after client 2 is served, clients 1 and 3 request -> client 3 is granted before client 1.
- Backpressure: `mem_req_ready` held low 5 cycles during a write -> `mem_req_valid`, `we`, `addr` and `wdata` stable for all 5 cycles; accepted on cycle 6.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): memory never responds -> `res_valid` for the granted client 8 cycles after WAIT entry, `res_err`=1, `res_rdata`=0. With the macro off, the arbiter stays in WAIT with `ready`=0.
- Reset in WAIT: `rst_n` low for one cycle, then a late `mem_res_valid` -> all outputs at reset values; no `res_valid` pulse; the next request is served normally.
